// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC temperature sampler.
package xadc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RDY,
        ACCUM,
        DONE
    } sampler_state_t;

    localparam logic [6:0]  XADC_ADDR_TEMP   = 7'h00;
    localparam logic [6:0]  XADC_ADDR_VCCINT = 7'h01;
    localparam int unsigned XADC_CODE_W      = 12;

    // Burst period in clock cycles; simulation builds use a short fixed period.
    function automatic int unsigned period_cycles(input int unsigned clk_hz,
                                                  input int unsigned period_us,
                                                  input bit          sim,
                                                  input int unsigned sim_cyc);
        return sim ? sim_cyc : (clk_hz / 1_000_000) * period_us;
    endfunction

endpackage

// File: rtl/xadc_temp_sampler_tick_gen.sv
// Periodic one-cycle tick for continuous-mode bursts.
module tick_gen #(
    parameter int unsigned PERIOD_CYC = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned      CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count while enabled and wrap at the period; park at zero when disabled.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/xadc_temp_sampler.sv
// XADC DRP temperature sampler: reads the temperature register in bursts of
// 2^AVG_LOG2 samples and presents the truncated average to TempSensor.
module xadc_temp_sampler
    import xadc_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 10_000_000,
    parameter int unsigned Simulacion       = 0,
    parameter int unsigned SAMPLE_PERIOD_US = 1000,
    parameter int unsigned SIM_PERIOD_CYC   = 100,
    parameter int unsigned AVG_LOG2         = 3,   // legal range 0..4
    parameter logic [6:0]  DRP_ADDR         = XADC_ADDR_TEMP,
    parameter int unsigned TIMEOUT_CYC      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        cont_en_i,
    output logic [6:0]  drp_daddr_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic [11:0] temp_raw_o,
    output logic        temp_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_timeout_o
);

    localparam int unsigned PERIOD_CYC =
        period_cycles(CLK_HZ, SAMPLE_PERIOD_US, Simulacion != 0, SIM_PERIOD_CYC);
    localparam int unsigned      SUM_W     = XADC_CODE_W + AVG_LOG2;
    localparam int unsigned      CNT_W     = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1 << AVG_LOG2);
    localparam int unsigned      WAIT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    sampler_state_t         state_q;
    logic [SUM_W-1:0]       sum_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_inc;
    logic [WAIT_W-1:0]      wait_q;
    logic [XADC_CODE_W-1:0] sample_q;
    logic [6:0]             daddr_q;
    logic                   den_q;
    logic [11:0]            raw_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   tick;
    logic                   trigger;

    tick_gen #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (cont_en_i),
        .tick  (tick)
    );

    // Start and tick landing together still form a single trigger.
    assign trigger = start_i || tick;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Burst sequencer; every output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            sample_q <= '0;
            daddr_q  <= DRP_ADDR;
            den_q    <= 1'b0;
            raw_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            den_q   <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q <= REQ;
                        den_q   <= 1'b1;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: begin
                    // drdy coinciding with den is deliberately not looked at here.
                    state_q <= WAIT_RDY;
                    wait_q  <= '0;
                end
                WAIT_RDY: begin
                    if (drp_drdy_i) begin
                        sample_q <= drp_do_i[15:4];
                        state_q  <= ACCUM;
                    end else if (wait_q == WAIT_LAST) begin
                        // Abandon the burst; temp_raw_o keeps the last good average.
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ACCUM: begin
                    sum_q <= sum_q + SUM_W'(sample_q);
                    cnt_q <= cnt_inc;
                    if (cnt_inc == N_SAMPLES) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= REQ;
                        den_q   <= 1'b1;
                    end
                end
                DONE: begin
                    raw_q   <= XADC_CODE_W'(sum_q >> AVG_LOG2);
                    valid_q <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign drp_daddr_o   = daddr_q;
    assign drp_den_o     = den_q;
    assign drp_dwe_o     = 1'b0;
    assign drp_di_o      = 16'h0000;
    assign temp_raw_o    = raw_q;
    assign temp_valid_o  = valid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_xadc_temp_sampler.sv
// Scoreboard bench for xadc_temp_sampler: three instances (AVG_LOG2 = 3, 2, 0),
// each with its own DRP slave model.
module tb_xadc_temp_sampler;
    import xadc_pkg::*;

    typedef struct {
        logic [11:0] code;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst, start, cont_en, den, dwe, drdy, valid, busy, done, err;
    logic [6:0]  daddr [3];
    logic [15:0] di    [3];
    logic [15:0] dout  [3];
    logic [11:0] raw   [3];

    exp_t        exp_q   [3][$];
    int          n_vec   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    int          den_cnt [3] = '{0, 0, 0};
    int          rem     [3] = '{0, 0, 0};
    int          vidx    [3] = '{0, 0, 0};
    int          d_lat   [3] = '{2, 2, 2};
    bit          hang    [3] = '{0, 0, 0};
    bit          spur    [3] = '{0, 0, 0};
    logic [15:0] vtab    [3][8];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        xadc_temp_sampler #(
            .CLK_HZ           (10_000_000),
            .Simulacion       (1),
            .SAMPLE_PERIOD_US (1000),
            .SIM_PERIOD_CYC   (100),
            .AVG_LOG2         (g == 0 ? 3 : (g == 1 ? 2 : 0)),
            .DRP_ADDR         (XADC_ADDR_TEMP),
            .TIMEOUT_CYC      (255)
        ) u_dut (
            .clk           (clk),
            .reset         (rst[g]),
            .start_i       (start[g]),
            .cont_en_i     (cont_en[g]),
            .drp_daddr_o   (daddr[g]),
            .drp_den_o     (den[g]),
            .drp_dwe_o     (dwe[g]),
            .drp_di_o      (di[g]),
            .drp_do_i      (dout[g]),
            .drp_drdy_i    (drdy[g]),
            .temp_raw_o    (raw[g]),
            .temp_valid_o  (valid[g]),
            .busy_o        (busy[g]),
            .done_o        (done[g]),
            .err_timeout_o (err[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // DRP slave model: drdy arrives d_lat cycles after the den cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            drdy[i] <= 1'b0;
            if (den[i] === 1'b1) begin
                den_cnt[i]++;
                if (!hang[i]) rem[i] = d_lat[i];
            end
            if (rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    drdy[i] <= 1'b1;
                    dout[i] <= vtab[i][vidx[i] % 8];
                    vidx[i]++;
                end
            end
            if (spur[i]) begin
                drdy[i] <= 1'b1;
                dout[i] <= 16'hEEE0;
            end
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, required %0h (cycle %0d)", name, idx, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the head of that instance's queue.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid[%0d]: got pulse code %0h at cycle %0d, required none",
                             i, raw[i], cyc);
                end else begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    check("temp_raw", i, 32'(raw[i]), 32'(e.code));
                    check("valid_cycle", i, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int i, input logic [11:0] code, input int c);
        exp_t e;
        e.code = code;
        e.cyc  = c;
        exp_q[i].push_back(e);
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        step(1);
        start[i] = 1'b0;
    endtask

    task automatic wait_drain(input int i, input int budget);
        int k = 0;
        while (exp_q[i].size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        if (exp_q[i].size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout[%0d]: got %0d pending, required 0", i, exp_q[i].size());
            exp_q[i].delete();
        end
    endtask

    task automatic fill(input int i, input logic [15:0] v);
        for (int k = 0; k < 8; k++) vtab[i][k] = v;
        vidx[i] = 0;
    endtask

    int t0, dc;

    initial begin
        rst     = 3'b111;
        start   = 3'b000;
        cont_en = 3'b000;
        for (int i = 0; i < 3; i++) fill(i, 16'h0000);
        step(3);
        for (int i = 0; i < 3; i++) begin
            check("rst_den", i, 32'(den[i]), 32'd0);
            check("rst_daddr", i, 32'(daddr[i]), 32'h00);
            check("rst_raw", i, 32'(raw[i]), 32'd0);
            check("rst_valid", i, 32'(valid[i]), 32'd0);
            check("rst_busy", i, 32'(busy[i]), 32'd0);
            check("rst_done", i, 32'(done[i]), 32'd0);
            check("rst_err", i, 32'(err[i]), 32'd0);
            check("dwe_di", i, {15'd0, dwe[i], di[i]}, 32'd0);
        end
        rst = 3'b000;
        step(2);

        // Single 8-sample burst, d=2: valid 1 + 8*4 + 1 = 34 cycles after start.
        fill(0, 16'h9A30);
        d_lat[0] = 2;
        dc = den_cnt[0];
        t0 = cyc;
        push_exp(0, 12'h9A3, t0 + 34);
        pulse_start(0);
        check("den_first", 0, 32'(den[0]), 32'd1);
        check("busy_in_burst", 0, 32'(busy[0]), 32'd1);
        wait_drain(0, 100);
        check("den_pulses", 0, 32'(den_cnt[0] - dc), 32'd8);
        check("done_after", 0, 32'(done[0]), 32'd1);
        check("busy_after", 0, 32'(busy[0]), 32'd0);

        // drdy while idle must not disturb anything.
        spur[0] = 1'b1;
        step(1);
        spur[0] = 1'b0;
        step(3);
        check("spur_raw", 0, 32'(raw[0]), 32'h9A3);
        check("spur_busy", 0, 32'(busy[0]), 32'd0);

        // Truncating average, 4 samples: (100+101+101+101)>>2 = 100; d=3 -> 22 cycles.
        vtab[1][0] = 16'h100F;
        vtab[1][1] = 16'h101A;
        vtab[1][2] = 16'h1015;
        vtab[1][3] = 16'h101F;
        vidx[1]  = 0;
        d_lat[1] = 3;
        dc = den_cnt[1];
        t0 = cyc;
        push_exp(1, 12'h100, t0 + 22);
        pulse_start(1);
        wait_drain(1, 60);
        check("den_pulses", 1, 32'(den_cnt[1] - dc), 32'd4);

        // Timeout: no drdy ever; 255 wait cycles then error, average untouched.
        hang[0] = 1'b1;
        dc = den_cnt[0];
        t0 = cyc;
        pulse_start(0);
        check("done_cleared", 0, 32'(done[0]), 32'd0);
        step(t0 + 250 - cyc);
        check("err_early", 0, 32'(err[0]), 32'd0);
        check("busy_waiting", 0, 32'(busy[0]), 32'd1);
        step(t0 + 262 - cyc);
        check("err_set", 0, 32'(err[0]), 32'd1);
        check("busy_timeout", 0, 32'(busy[0]), 32'd0);
        check("raw_kept", 0, 32'(raw[0]), 32'h9A3);
        check("den_timeout", 0, 32'(den_cnt[0] - dc), 32'd1);
        hang[0] = 1'b0;

        // Normal burst after timeout, with a start injected mid-burst.
        fill(0, 16'h5550);
        dc = den_cnt[0];
        t0 = cyc;
        push_exp(0, 12'h555, t0 + 34);
        pulse_start(0);
        step(8);
        pulse_start(0);
        wait_drain(0, 100);
        check("den_busy_start", 0, 32'(den_cnt[0] - dc), 32'd8);
        check("err_sticky", 0, 32'(err[0]), 32'd1);

        // Reset while in WAIT_RDY; drdy lands the following cycle.
        fill(1, 16'h7770);
        d_lat[1] = 2;
        dc = den_cnt[1];
        pulse_start(1);
        step(1);
        check("busy_wait", 1, 32'(busy[1]), 32'd1);
        rst[1] = 1'b1;
        step(1);
        rst[1] = 1'b0;
        check("mid_rst_den", 1, 32'(den[1]), 32'd0);
        check("mid_rst_raw", 1, 32'(raw[1]), 32'd0);
        check("mid_rst_busy", 1, 32'(busy[1]), 32'd0);
        check("mid_rst_done", 1, 32'(done[1]), 32'd0);
        check("mid_rst_valid", 1, 32'(valid[1]), 32'd0);
        step(10);
        check("den_after_rst", 1, 32'(den_cnt[1] - dc), 32'd1);
        check("busy_after_rst", 1, 32'(busy[1]), 32'd0);
        fill(1, 16'h0420);
        t0 = cyc;
        push_exp(1, 12'h042, t0 + 18);
        pulse_start(1);
        wait_drain(1, 60);

        // Continuous mode, AVG_LOG2=0, d=1: ticks at +99/+199/+299, valid 5 later.
        vtab[2][0] = 16'h1230;
        vtab[2][1] = 16'h4560;
        vtab[2][2] = 16'h7890;
        vidx[2]  = 0;
        d_lat[2] = 1;
        dc = den_cnt[2];
        t0 = cyc;
        cont_en[2] = 1'b1;
        push_exp(2, 12'h123, t0 + 104);
        push_exp(2, 12'h456, t0 + 204);
        push_exp(2, 12'h789, t0 + 304);
        step(201);
        pulse_start(2);               // lands in WAIT_RDY of the second burst
        step(t0 + 299 - cyc);
        pulse_start(2);               // coincides with the third tick
        step(t0 + 350 - cyc);
        cont_en[2] = 1'b0;
        step(10);
        check("den_cont", 2, 32'(den_cnt[2] - dc), 32'd3);
        check("raw_cont", 2, 32'(raw[2]), 32'h789);
        check("done_cont", 2, 32'(done[2]), 32'd1);

        for (int i = 0; i < 3; i++) check("queue_empty", i, 32'(exp_q[i].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
        $fatal(1);
    end

endmodule
